// File: rtl/tin_psum_acc.sv
// Accumulates Tin-reduced adder-tree sums over cfg_len terms into saturated
// partial sums, cfg_num_out per job, with valid re-timed to the tree latency.
module tin_psum_acc #(
  parameter int IN_WIDTH  = 36,
  parameter int ACC_WIDTH = 52,
  parameter int OUT_WIDTH = 32,
  parameter int LEN_WIDTH = 16,
  parameter int ALIGN_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [LEN_WIDTH-1:0] cfg_num_out,
  input  logic                 i_vld,
  input  logic [IN_WIDTH-1:0]  i_dat,
  output logic [OUT_WIDTH-1:0] o_dat,
  output logic                 o_vld,
  output logic                 o_ovf,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                       r_state;
  logic [LEN_WIDTH-1:0]         r_len, r_num, r_term_cnt, r_out_cnt;
  logic [2*LEN_WIDTH-1:0]       r_issue_cnt;
  logic [ALIGN_LAT:1]           r_vld_pipe;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic [OUT_WIDTH-1:0]         r_dat;
  logic                         r_vld, r_ovf, r_done;

  logic [2*LEN_WIDTH-1:0]       w_total;
  logic                         w_acc, w_avld, w_last_term, w_last_out, w_hi, w_lo;
  logic signed [ACC_WIDTH-1:0]  w_term, w_sum;
  logic [OUT_WIDTH-1:0]         w_sat;

  assign w_total = {{LEN_WIDTH{1'b0}}, r_len} * {{LEN_WIDTH{1'b0}}, r_num};
  // The start cycle reconfigures the job, so an i_vld in that cycle is dropped.
  assign w_acc   = (r_state == S_RUN) && i_vld && !i_start && (r_issue_cnt < w_total);
  assign w_avld  = r_vld_pipe[ALIGN_LAT];

  assign w_term      = {{(ACC_WIDTH-IN_WIDTH){i_dat[IN_WIDTH-1]}}, i_dat};
  assign w_sum       = (r_term_cnt == '0) ? w_term : r_acc + w_term;
  assign w_last_term = (r_term_cnt == r_len - LEN_WIDTH'(1));
  assign w_last_out  = (r_out_cnt == r_num - LEN_WIDTH'(1));
  assign w_hi        = (w_sum > SAT_MAX);
  assign w_lo        = (w_sum < SAT_MIN);
  assign w_sat       = w_hi ? SAT_MAX[OUT_WIDTH-1:0] :
                       w_lo ? SAT_MIN[OUT_WIDTH-1:0] : w_sum[OUT_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_num       <= '0;
      r_term_cnt  <= '0;
      r_out_cnt   <= '0;
      r_issue_cnt <= '0;
      r_vld_pipe  <= '0;
      r_acc       <= '0;
      r_dat       <= '0;
      r_vld       <= 1'b0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_vld  <= 1'b0;
      r_done <= 1'b0;
      r_vld_pipe[1] <= w_acc;
      for (int i = 2; i <= ALIGN_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      if (i_start) begin
        // Restart from any state: in-flight terms of an old job are flushed.
        r_len       <= cfg_len;
        r_num       <= cfg_num_out;
        r_term_cnt  <= '0;
        r_out_cnt   <= '0;
        r_issue_cnt <= '0;
        r_vld_pipe  <= '0;
        r_acc       <= '0;
        r_ovf       <= 1'b0;
        if (cfg_len == '0 || cfg_num_out == '0) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end else begin
          r_state <= S_RUN;
        end
      end else begin
        if (w_acc) r_issue_cnt <= r_issue_cnt + (2*LEN_WIDTH)'(1);
        if (w_avld) begin
          r_acc <= w_sum;
          if (w_last_term) begin
            r_term_cnt <= '0;
            r_out_cnt  <= r_out_cnt + LEN_WIDTH'(1);
            r_vld      <= 1'b1;
            r_dat      <= w_sat;
            if (w_hi || w_lo) r_ovf <= 1'b1;
            if (w_last_out) r_done <= 1'b1;
          end else begin
            r_term_cnt <= r_term_cnt + LEN_WIDTH'(1);
          end
        end
        if (r_state == S_RUN && r_done) r_state <= S_IDLE;
      end
    end
  end

  assign o_dat  = r_dat;
  assign o_vld  = r_vld;
  assign o_ovf  = r_ovf;
  assign o_done = r_done;
  assign o_busy = (r_state == S_RUN);

endmodule

// File: tb/tb_tin_psum_acc.sv
// Directed + randomized bench for tin_psum_acc against a sum-per-group model.
module tb_tin_psum_acc;
  localparam int IW = 36, AW = 52, OW = 32, LW = 16, AL = 4;

  logic          clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_vld = 1'b0;
  logic [LW-1:0] cfg_len = '0, cfg_num_out = '0;
  logic [IW-1:0] i_dat = '0;
  logic [OW-1:0] o_dat;
  logic          o_vld, o_ovf, o_busy, o_done;

  tin_psum_acc #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .LEN_WIDTH(LW),
                 .ALIGN_LAT(AL)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .cfg_len(cfg_len),
    .cfg_num_out(cfg_num_out), .i_vld(i_vld), .i_dat(i_dat), .o_dat(o_dat),
    .o_vld(o_vld), .o_ovf(o_ovf), .o_busy(o_busy), .o_done(o_done));

  always #5 clk = ~clk;

  int     tests = 0, fails = 0;
  int     ncall = 0, last_ivld = -1, last_ovld = -1;
  int     n_done = 0, done_bad = 0, cur_num = 0;
  longint q_out[$];
  longint terms_q[$];
  longint sched[AL];

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, emulate tree latency on i_dat, sample after edge.
  task automatic cyc(input logic st, input logic v, input longint val);
    longint dv;
    dv = sched[AL-1];
    for (int k = AL-1; k > 0; k--) sched[k] = sched[k-1];
    sched[0] = v ? val : 64'sd0;
    i_start = st;
    i_vld   = v;
    i_dat   = dv[IW-1:0];
    if (v) last_ivld = ncall;
    @(posedge clk); #1;
    if (o_vld) begin
      q_out.push_back(longint'($signed(o_dat)));
      last_ovld = ncall;
    end
    if (o_done) begin
      n_done++;
      if (!o_vld || q_out.size() != cur_num) done_bad++;
    end
    ncall++;
    i_start = 1'b0;
  endtask

  task automatic do_start(input int len, input int num);
    cfg_len = LW'(len);
    cfg_num_out = LW'(num);
    q_out.delete();
    n_done = 0;
    done_bad = 0;
    cur_num = num;
    cyc(1'b1, 1'b0, 0);
  endtask

  // Runs a job over terms_q; extra i_vld beyond len*num must be ignored.
  task automatic run_job(input int len, input int num, input int extra, input bit gaps);
    int total, issued, k;
    longint s, sat, exp_q[$];
    bit exp_ovf;
    total = len * num;
    do_start(len, num);
    chk("ovf_clr_on_start", longint'(o_ovf), 0);
    chk("busy_after_start", longint'(o_busy), 1);
    issued = 0;
    while (issued < total + extra) begin
      if (gaps && $urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 0);
      else begin
        cyc(1'b0, 1'b1, issued < total ? terms_q[issued] : longint'($urandom_range(0, 999)));
        issued++;
      end
    end
    for (k = 0; k < 40 && o_busy; k++) cyc(1'b0, 1'b0, 0);
    chk("drain_timeout", longint'(o_busy), 0);
    exp_ovf = 1'b0;
    for (int o = 0; o < num; o++) begin
      s = 0;
      for (int t = 0; t < len; t++) s += terms_q[o*len + t];
      sat = s;
      if (s > 64'sd2147483647) sat = 64'sd2147483647;
      if (s < -64'sd2147483648) sat = -64'sd2147483648;
      if (sat != s) exp_ovf = 1'b1;
      exp_q.push_back(sat);
    end
    chk("n_vld", q_out.size(), num);
    for (int o = 0; o < num && o < q_out.size(); o++) chk("o_dat", q_out[o], exp_q[o]);
    chk("n_done", n_done, 1);
    chk("done_with_last_vld", done_bad, 0);
    chk("o_ovf", longint'(o_ovf), longint'(exp_ovf));
  endtask

  initial begin
    int len, num;
    for (int k = 0; k < AL; k++) sched[k] = 0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_dat", longint'(o_dat), 0);
    chk("rst_flags", longint'({o_vld, o_ovf, o_busy, o_done}), 0);
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 0);

    // Two IDLE pulses, then the basic two-output job
    cyc(1'b0, 1'b1, 55);
    cyc(1'b0, 1'b1, 66);
    terms_q = '{5, -2, 7, 100, 200, 300};
    run_job(3, 2, 0, 1'b0);

    // Latency: last i_vld call -> o_vld seen AL calls later (AL+1 cycles)
    terms_q = '{-9};
    run_job(1, 1, 0, 1'b0);
    chk("latency", last_ovld - last_ivld, AL);

    // Saturation both ways; ovf clears on next start (checked in run_job)
    terms_q = '{64'sh7FFFFFFF, 1};
    run_job(2, 1, 0, 1'b0);
    terms_q = '{-64'sd2147483648, -1};
    run_job(2, 1, 0, 1'b0);

    // Gating: two excess pulses beyond len*num
    terms_q = '{11, 22};
    run_job(2, 1, 2, 1'b0);

    // Abort after 1 of 3 terms; restart with len=2
    do_start(3, 1);
    cyc(1'b0, 1'b1, 1000);
    cyc(1'b0, 1'b0, 0);
    terms_q = '{4, 4};
    run_job(2, 1, 0, 1'b0);

    // Degenerate configs
    do_start(0, 3);
    chk("deg_len_done", longint'({o_done, o_vld, o_busy}), 3'b100);
    cyc(1'b0, 1'b0, 0);
    chk("deg_len_after", longint'({o_done, o_busy}), 0);
    do_start(2, 0);
    chk("deg_num_done", longint'({o_done, o_vld, o_busy}), 3'b100);

    // Randomized jobs with gaps, excess pulses and occasional huge terms
    for (int j = 0; j < 10; j++) begin
      len = $urandom_range(1, 5);
      num = $urandom_range(1, 4);
      terms_q.delete();
      for (int t = 0; t < len * num; t++) begin
        if ($urandom_range(0, 3) == 0)
          terms_q.push_back(longint'($urandom_range(0, 32'h7FFFFFFF)) * 4 - 64'sd4294967296);
        else
          terms_q.push_back(longint'($urandom_range(0, 20000)) - 10000);
      end
      run_job(len, num, $urandom_range(0, 2), 1'b1);
    end

    // Reset mid-job: outputs clear and no strobes follow
    do_start(3, 2);
    repeat (4) cyc(1'b0, 1'b1, 77);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_o_dat", longint'(o_dat), 0);
    chk("midrst_flags", longint'({o_vld, o_ovf, o_busy, o_done}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    q_out.delete();
    n_done = 0;
    repeat (12) cyc(1'b0, 1'b0, 0);
    chk("midrst_no_vld", q_out.size(), 0);
    chk("midrst_no_done", n_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
